// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 4-digit 7-segment display path.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package disp_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] DIG_OFF   = 4'hF;

    localparam logic [7:0] SEG_HEX_0 = 8'hC0;
    localparam logic [7:0] SEG_HEX_1 = 8'hF9;
    localparam logic [7:0] SEG_HEX_2 = 8'hA4;
    localparam logic [7:0] SEG_HEX_3 = 8'hB0;
    localparam logic [7:0] SEG_HEX_4 = 8'h99;
    localparam logic [7:0] SEG_HEX_5 = 8'h92;
    localparam logic [7:0] SEG_HEX_6 = 8'h82;
    localparam logic [7:0] SEG_HEX_7 = 8'hF8;
    localparam logic [7:0] SEG_HEX_8 = 8'h80;
    localparam logic [7:0] SEG_HEX_9 = 8'h90;
    localparam logic [7:0] SEG_HEX_A = 8'h88;
    localparam logic [7:0] SEG_HEX_B = 8'h83;
    localparam logic [7:0] SEG_HEX_C = 8'hC6;
    localparam logic [7:0] SEG_HEX_D = 8'hA1;
    localparam logic [7:0] SEG_HEX_E = 8'h86;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [7:0] hex_seg(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = SEG_HEX_0;
            4'h1:    code = SEG_HEX_1;
            4'h2:    code = SEG_HEX_2;
            4'h3:    code = SEG_HEX_3;
            4'h4:    code = SEG_HEX_4;
            4'h5:    code = SEG_HEX_5;
            4'h6:    code = SEG_HEX_6;
            4'h7:    code = SEG_HEX_7;
            4'h8:    code = SEG_HEX_8;
            4'h9:    code = SEG_HEX_9;
            4'hA:    code = SEG_HEX_A;
            4'hB:    code = SEG_HEX_B;
            4'hC:    code = SEG_HEX_C;
            4'hD:    code = SEG_HEX_D;
            4'hE:    code = SEG_HEX_E;
            4'hF:    code = SEG_HEX_F;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to active-low 7-segment decoder; dp=1 lights the
// decimal point by clearing bit 7.
module seg_hex_dec
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    input  logic       dp,
    output logic [7:0] seg
);

    // Decode the nibble, then let the decimal point override bit 7
    always_comb begin
        seg    = hex_seg(nib);
        seg[7] = ~dp;
    end

endmodule

// File: rtl/disp_share_arb.sv
// Round-robin owner arbitration with minimum dwell for a shared 4-digit display,
// plus the digit scan with a blanking gap at every digit change.
module disp_share_arb
    import disp_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int SCAN_DIV    = 125000,
    parameter int BLANK_CYC   = 2500,
    parameter int DWELL_SLOTS = 400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [16*NREQ-1:0] data,
    input  logic [4*NREQ-1:0] dp,
    output logic [NREQ-1:0]   gnt,
    output logic [3:0]        dig,
    output logic [7:0]        seg
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int OWN_W = $clog2(NREQ);
    localparam int DW_W  = $clog2(DWELL_SLOTS + 1);

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [DW_W-1:0]  DWELL_MAX  = DW_W'(DWELL_SLOTS);
    localparam logic [OWN_W-1:0] OWN_INIT   = OWN_W'(NREQ - 1);

    logic [CNT_W-1:0] slot_cnt_r;
    logic [1:0]       idx_r;
    arb_state_e       state_r;
    logic [OWN_W-1:0] owner_r;
    logic [OWN_W-1:0] last_r;
    logic [DW_W-1:0]  dwell_r;
    logic [NREQ-1:0]  gnt_r;
    logic [3:0]       dig_r;
    logic [7:0]       seg_r;

    logic             boundary_s;
    logic             blank_end_s;
    logic [NREQ-1:0]  cand_s;
    logic             own_req_s;
    logic             found_s;
    logic [OWN_W-1:0] pick_s;
    arb_state_e       state_nx_s;
    logic [OWN_W-1:0] owner_nx_s;
    logic [OWN_W-1:0] last_nx_s;
    logic [DW_W-1:0]  dwell_nx_s;
    logic [1:0]       idx_nx_s;
    logic [NREQ-1:0]  gnt_nx_s;
    logic [15:0]      word_s;
    logic [3:0]       dp4_s;
    logic [3:0]       nib_s;
    logic             dp_bit_s;
    logic [7:0]       seg_dec_s;

    assign boundary_s  = (slot_cnt_r == SLOT_LAST);
    assign blank_end_s = (BLANK_CYC > 0) && (slot_cnt_r == BLANK_LAST);
    assign idx_nx_s    = idx_r + 2'd1;

    // Round-robin pick among pending requests (current owner excluded), scanning from last+1
    always_comb begin
        own_req_s = 1'b0;
        cand_s    = '0;
        found_s   = 1'b0;
        pick_s    = last_r;
        for (int i = 0; i < NREQ; i++) begin
            own_req_s = own_req_s | (req[i] & (owner_r == OWN_W'(i)));
            cand_s[i] = req[i] & ~((state_r == ARB_GRANT) && (owner_r == OWN_W'(i)));
        end
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                pick_s  = (!found_s && cand_s[i] && (((int'(last_r) + k) % NREQ) == i))
                          ? OWN_W'(i) : pick_s;
                found_s = found_s | (cand_s[i] && (((int'(last_r) + k) % NREQ) == i));
            end
        end
    end

    // Arbiter next-state; only committed at slot boundaries
    always_comb begin
        state_nx_s = state_r;
        owner_nx_s = owner_r;
        last_nx_s  = last_r;
        dwell_nx_s = dwell_r;
        case (state_r)
            ARB_IDLE: begin
                if (found_s) begin
                    state_nx_s = ARB_GRANT;
                    owner_nx_s = pick_s;
                    last_nx_s  = pick_s;
                    dwell_nx_s = '0;
                end else begin
                    state_nx_s = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (!own_req_s) begin
                    if (found_s) begin
                        owner_nx_s = pick_s;
                        last_nx_s  = pick_s;
                        dwell_nx_s = '0;
                    end else begin
                        state_nx_s = ARB_IDLE;
                    end
                end else if (found_s && (dwell_r >= DWELL_MAX)) begin
                    owner_nx_s = pick_s;
                    last_nx_s  = pick_s;
                    dwell_nx_s = '0;
                end else begin
                    dwell_nx_s = (dwell_r >= DWELL_MAX) ? DWELL_MAX : dwell_r + DW_W'(1);
                end
            end
            default: begin
                state_nx_s = ARB_IDLE;
            end
        endcase
    end

    // Select the incoming owner's word and the nibble for the incoming digit
    always_comb begin
        word_s   = 16'h0000;
        dp4_s    = 4'h0;
        gnt_nx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            word_s      = word_s | ((owner_nx_s == OWN_W'(i)) ? data[i*16 +: 16] : 16'h0000);
            dp4_s       = dp4_s | ((owner_nx_s == OWN_W'(i)) ? dp[i*4 +: 4] : 4'h0);
            gnt_nx_s[i] = (state_nx_s == ARB_GRANT) && (owner_nx_s == OWN_W'(i));
        end
        nib_s    = word_s[{idx_nx_s, 2'b00} +: 4];
        dp_bit_s = dp4_s[idx_nx_s];
    end

    seg_hex_dec u_dec (
        .nib (nib_s),
        .dp  (dp_bit_s),
        .seg (seg_dec_s)
    );

    // Slot counter and free-running digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_r <= '0;
            idx_r      <= 2'd3;
        end else if (boundary_s) begin
            slot_cnt_r <= '0;
            idx_r      <= idx_nx_s;
        end else begin
            slot_cnt_r <= slot_cnt_r + CNT_W'(1);
            idx_r      <= idx_r;
        end
    end

    // Arbiter state, owner, round-robin pointer and dwell counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
            owner_r <= '0;
            last_r  <= OWN_INIT;
            dwell_r <= '0;
        end else if (boundary_s) begin
            state_r <= state_nx_s;
            owner_r <= owner_nx_s;
            last_r  <= last_nx_s;
            dwell_r <= dwell_nx_s;
        end else begin
            state_r <= state_r;
            owner_r <= owner_r;
            last_r  <= last_r;
            dwell_r <= dwell_r;
        end
    end

    // Grant, segments and digit enables change together so no owner's pattern
    // ever appears under another owner's digit enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r <= '0;
            seg_r <= SEG_BLANK;
            dig_r <= DIG_OFF;
        end else if (boundary_s) begin
            gnt_r <= gnt_nx_s;
            seg_r <= (state_nx_s == ARB_GRANT) ? seg_dec_s : SEG_BLANK;
            dig_r <= ((BLANK_CYC == 0) && (state_nx_s == ARB_GRANT))
                     ? ~(4'b0001 << idx_nx_s) : DIG_OFF;
        end else if (blank_end_s) begin
            gnt_r <= gnt_r;
            seg_r <= seg_r;
            dig_r <= (state_r == ARB_GRANT) ? ~(4'b0001 << idx_r) : DIG_OFF;
        end else begin
            gnt_r <= gnt_r;
            seg_r <= seg_r;
            dig_r <= dig_r;
        end
    end

    assign gnt = gnt_r;
    assign dig = dig_r;
    assign seg = seg_r;

endmodule

// File: tb/tb_disp_share_arb.sv
// Self-checking bench for disp_share_arb: directed table/sequences plus a
// cycle-level reference model compared every cycle under random requests.
module tb_disp_share_arb;

    localparam int SD = 8;
    localparam int BL = 2;
    localparam int DW = 4;
    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [2:0]    req = 3'b000;
    logic [47:0]   data = 48'h0;
    logic [11:0]   dp = 12'h0;
    logic [2:0]    gnt;
    logic [3:0]    dig;
    logic [7:0]    seg;

    int vecs = 0;
    int errs = 0;
    bit chk_on = 1'b0;

    disp_share_arb #(
        .NREQ(NR), .SCAN_DIV(SD), .BLANK_CYC(BL), .DWELL_SLOTS(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data), .dp(dp),
        .gnt(gnt), .dig(dig), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         pos;
        int         idx;
        bit         granted;
        int         owner;
        int         last;
        int         dwell;
        logic [2:0] gnt;
        logic [3:0] dig;
        logic [7:0] seg;
    } model_t;

    model_t m;

    function automatic logic [7:0] seg_of(input logic [3:0] nib, input logic lit);
        logic [7:0] c;
        case (nib)
            4'h0: c = 8'hC0; 4'h1: c = 8'hF9; 4'h2: c = 8'hA4; 4'h3: c = 8'hB0;
            4'h4: c = 8'h99; 4'h5: c = 8'h92; 4'h6: c = 8'h82; 4'h7: c = 8'hF8;
            4'h8: c = 8'h80; 4'h9: c = 8'h90; 4'hA: c = 8'h88; 4'hB: c = 8'h83;
            4'hC: c = 8'hC6; 4'hD: c = 8'hA1; 4'hE: c = 8'h86; default: c = 8'h8E;
        endcase
        if (lit) c = c & 8'h7F;
        return c;
    endfunction

    function automatic model_t model_reset();
        model_t r;
        r.pos = 0; r.idx = 3; r.granted = 1'b0; r.owner = 0; r.last = NR - 1;
        r.dwell = 0; r.gnt = 3'b000; r.dig = 4'hF; r.seg = 8'hFF;
        return r;
    endfunction

    // One clock of the display behaviour, computed from the rules directly
    function automatic model_t model_next(input model_t c, input logic [2:0] r,
                                          input logic [47:0] d, input logic [11:0] p);
        model_t n;
        bit others;
        bit may_move;
        bit done;
        int j;
        n = c;
        n.pos = (c.pos + 1) % SD;
        if (c.pos == SD - 1) begin
            n.idx = (c.idx + 1) % 4;
            others = 1'b0;
            for (int i = 0; i < NR; i++)
                if (r[i] && !(c.granted && i == c.owner)) others = 1'b1;
            may_move = !c.granted || !r[c.owner] || (c.dwell >= DW);
            if (others && may_move) begin
                done = 1'b0;
                for (int k = 1; k <= NR; k++) begin
                    j = (c.last + k) % NR;
                    if (!done && r[j] && !(c.granted && j == c.owner)) begin
                        n.owner = j; n.last = j; n.dwell = 0; n.granted = 1'b1; done = 1'b1;
                    end
                end
            end else if (c.granted && !r[c.owner]) begin
                n.granted = 1'b0;
            end else if (c.granted) begin
                n.dwell = (c.dwell + 1 > DW) ? DW : c.dwell + 1;
            end
            n.gnt = n.granted ? 3'(1 << n.owner) : 3'b000;
            n.seg = n.granted ? seg_of(d[16*n.owner + 4*n.idx +: 4], p[4*n.owner + n.idx]) : 8'hFF;
            n.dig = 4'hF;
        end
        if (BL > 0 && c.pos == BL - 1)
            n.dig = n.granted ? ~(4'b0001 << n.idx) : 4'hF;
        return n;
    endfunction

    // Reference model register
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m, req, data, dp);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_gnt", {29'h0, gnt}, {29'h0, m.gnt});
            chk("model_dig", {28'h0, dig}, {28'h0, m.dig});
            chk("model_seg", {24'h0, seg}, {24'h0, m.seg});
        end
    end

    // Stop at the negedge just before a boundary; want_idx<0 means any digit
    task automatic wait_pre(input int want_idx);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 8 * SD && !ok; i++) begin
            @(negedge clk);
            if (m.pos == SD - 1 && (want_idx < 0 || (m.idx + 1) % 4 == want_idx)) ok = 1'b1;
        end
        if (!ok) begin
            vecs++; errs++;
            $display("FAIL wait_timeout: got no boundary expected boundary within %0d cycles", 8 * SD);
        end
    endtask

    task automatic wait_boundary(input int want_idx);
        wait_pre(want_idx);
        @(posedge clk); #1;
    endtask

    // Called just after the boundary opening digit k's slot
    task automatic slot_check(input int k, input logic [7:0] es);
        chk("tbl_seg", {24'h0, seg}, {24'h0, es});
        chk("tbl_dig_blank", {28'h0, dig}, 32'h0000000F);
        chk("tbl_gnt", {29'h0, gnt}, 32'h1);
        repeat (BL) @(posedge clk);
        #1 chk("tbl_dig_on", {28'h0, dig}, {28'h0, ~(4'b0001 << k)});
        repeat (SD - BL) @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [15:0] word;
        logic [3:0]  dpv;
        logic [31:0] segs;
    } vec_t;

    vec_t tbl [4];
    int   exp_g;

    initial begin
        tbl[0] = '{word: 16'h1234, dpv: 4'b0000, segs: {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        tbl[1] = '{word: 16'h5678, dpv: 4'b0101, segs: {8'h92, 8'h02, 8'hF8, 8'h00}};
        tbl[2] = '{word: 16'h9ABC, dpv: 4'b0000, segs: {8'h90, 8'h88, 8'h83, 8'hC6}};
        tbl[3] = '{word: 16'hDEF0, dpv: 4'b1000, segs: {8'h21, 8'h86, 8'h8E, 8'hC0}};

        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        chk("reset_gnt", {29'h0, gnt}, 32'h0);
        chk("reset_dig", {28'h0, dig}, 32'hF);
        chk("reset_seg", {24'h0, seg}, 32'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (40) @(negedge clk);
        chk("idle_gnt", {29'h0, gnt}, 32'h0);
        chk("idle_seg", {24'h0, seg}, 32'hFF);

        // First request: granted exactly at the next boundary
        req = 3'b001;
        data[15:0] = tbl[0].word;
        dp[3:0] = tbl[0].dpv;
        wait_pre(-1);
        chk("pre_grant_gnt", {29'h0, gnt}, 32'h0);
        @(posedge clk); #1;
        chk("first_grant", {29'h0, gnt}, 32'h1);

        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            data[15:0] = tbl[r].word;
            dp[3:0] = tbl[r].dpv;
            wait_boundary(0);
            for (int k = 0; k < 4; k++) slot_check(k, tbl[r].segs[k*8 +: 8]);
        end

        // Dwell: fresh grant to 0, then 1 competes
        @(negedge clk); req = 3'b000;
        wait_boundary(-1);
        chk("release_idle", {29'h0, gnt}, 32'h0);
        req = 3'b001;
        wait_boundary(-1);
        chk("regrant", {29'h0, gnt}, 32'h1);
        req = 3'b011;
        for (int j = 1; j <= 10; j++) begin
            wait_boundary(-1);
            exp_g = (j < 5) ? 1 : ((j < 10) ? 2 : 1);
            chk("dwell_rotate", {29'h0, gnt}, exp_g);
        end

        // Mid-slot release takes effect only at the boundary
        req = 3'b001;
        repeat (3) @(negedge clk);
        req = 3'b000;
        wait_pre(-1);
        chk("release_hold", {29'h0, gnt}, 32'h1);
        @(posedge clk); #1;
        chk("release_gnt", {29'h0, gnt}, 32'h0);
        chk("release_seg", {24'h0, seg}, 32'hFF);
        chk("release_dig", {28'h0, dig}, 32'hF);

        // Owner drop and new request on the same boundary
        @(negedge clk);
        req = 3'b001;
        data[47:32] = 16'h8888;
        dp[11:8] = 4'b0000;
        wait_boundary(-1);
        chk("swap_pre", {29'h0, gnt}, 32'h1);
        wait_pre(-1);
        req = 3'b100;
        @(posedge clk); #1;
        chk("swap_gnt", {29'h0, gnt}, 32'h4);
        chk("swap_seg", {24'h0, seg}, 32'h80);

        // Asynchronous reset while digit 1 is lit
        wait_boundary(1);
        repeat (BL) @(posedge clk);
        #1 chk("pre_reset_dig", {28'h0, dig}, 32'hD);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dig", {28'h0, dig}, 32'hF);
        chk("async_rst_seg", {24'h0, seg}, 32'hFF);
        chk("async_rst_gnt", {29'h0, gnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random requests and data against the model
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 63) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) data = {16'($urandom), $urandom};
            if ($urandom_range(0, 31) == 0) dp = 12'($urandom);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/disp_share_arb.md
# disp_share_arb

Shares the board's single 4-digit common-anode 7-segment display among `NREQ` requesters (counter, status and error sources), granting ownership round-robin with a minimum dwell time. The granted requester's 16-bit hex word is scanned onto the digits with a blanking gap at each digit change to suppress ghosting. The block sits between the producing blocks and the `dig`/`seg` pins and replaces per-source scan logic.

## Interface
- `NREQ`, 3: number of requesters, 2..8.
- `SCAN_DIV`, 125000: clk cycles per digit slot (50 MHz gives 2.5 ms/digit, 10 ms/frame).
- `BLANK_CYC`, 2500: cycles at the start of each slot with all digits off; 0 ≤ `BLANK_CYC` < `SCAN_DIV`.
- `DWELL_SLOTS`, 400: slots an owner keeps the grant before it can be pre-empted by another requester.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset; **one clock; reset is asynchronous and active-low**.
- `req`, in, `NREQ`: level request, bit i = requester i.
- `data`, in, 16·`NREQ`: requester i uses bits [16i+15:16i]; nibble k is digit k; digit 0 is the rightmost.
- `dp`, in, 4·`NREQ`: decimal points for requester i, bit k = digit k, 1 = lit.
- `gnt`, out, `NREQ`: one-hot or zero, registered.
- `dig`, out, 4: digit enables, active-low; `dig[k]`=0 enables digit k.
- `seg`, out, 8: active-low segments, {dp,g,f,e,d,c,b,a}.

## Operation
- Slot counter `slot_cnt` runs 0..`SCAN_DIV`-1 and wraps. A slot boundary is the edge where `slot_cnt`=`SCAN_DIV`-1.
- Digit index `idx` (2 bits) increments by 1 at every boundary, 3→0, independent of grant state.
- Arbiter FSM, evaluated only at boundaries:
  - IDLE: `gnt`=0. If any `req` is set, go to GRANT, choosing the owner round-robin starting from `last`+1, where `last` is the previous owner.
  - GRANT: if the owner's `req`=0, re-arbitrate among the remaining requests, or go to IDLE if none.
  - GRANT: if the owner's `req`=1, another `req` is set and `dwell`≥`DWELL_SLOTS`, rotate to the next requester after the owner.
  - GRANT: if the owner's `req`=1 and no other request is pending, keep the owner indefinitely.
- `dwell` clears on every new grant, increments per boundary and saturates at `DWELL_SLOTS`. `last` updates on every grant.
- Outputs at each boundary edge:
  - `seg` loads the decode of the new owner's nibble for the new `idx`, with dp bit = ~`dp`[owner][idx].
  - `seg`=8'hFF in IDLE.
  - `dig`=4'b1111.
- Outputs at the edge where `slot_cnt`=`BLANK_CYC`-1 (at the boundary edge itself if `BLANK_CYC`=0):
  - `dig` = ~(1<<`idx`) if GRANT; it stays 4'b1111 in IDLE.
- Data is sampled once per slot. Changes to `data` or `dp` mid-slot show on the next slot that displays that digit.
- Decode is full hex with active-low codes: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. The dp bit overrides bit 7.

## Timing
- Reset values (asynchronous, immediate, including mid-slot): `dig`=4'b1111, `seg`=8'hFF, `gnt`=0, `slot_cnt`=0, `idx`=3 (so the first boundary selects digit 0), `dwell`=0, `last`=`NREQ`-1 (requester 0 wins first), FSM=IDLE.
- Request-to-grant latency: 1 to `SCAN_DIV` cycles, ending at the next boundary edge. Release takes effect at the next boundary.
- The `gnt` change, `seg` reload and `dig` blanking occur on the same edge, so the display never shows one owner's segments on another owner's digit enable.
- Simultaneous drop of the owner's request and assertion of a new request at a boundary: the new requester is granted, with no IDLE slot in between.
- All outputs are registers; there are no combinational paths from `req` or `data` to outputs.

## Structure
- Package `disp_pkg`:
  - `SEG_BLANK`=8'hFF, `DIG_OFF`=4'hF.
  - The 16-entry segment code constants.
- Sub-module `seg_hex_dec`: combinational 4-bit nibble + dp → 8-bit active-low `seg`, reused by other display blocks.
- Top module contains the slot/idx counters, the arbiter FSM with dwell counter, and the output registers.

## Test plan
Run with `SCAN_DIV`=8, `BLANK_CYC`=2, `DWELL_SLOTS`=4, `NREQ`=3.
- Reset, then no requests for 40 cycles → `gnt`=0, `dig`=1111, `seg`=FF throughout.
- `req`=001, `data0`=16'h1234, `dp0`=0 → `gnt`=001 at the first boundary. Digits cycle 0..3 with `seg` 99, B0, A4, F9. `dig` is 1111 for 2 cycles, then 1110, 1101, 1011, 0111 for 6 cycles each.
- `req`=011 held → owner 0 keeps the grant for 4 slots, then `gnt`=010 at the 5th boundary, and back to 001 after 4 more slots.
- `req` drops 001→000 mid-slot → `gnt`=0 and `seg`=FF exactly at the next boundary, not before.
- At one boundary, `req` goes 001→100 → `gnt` goes 001→100 on that edge with no idle slot; the `seg` decode comes from `data2`.
- Assert `rst_n`=0 mid-slot while `dig`=1101 → `dig`=1111, `seg`=FF, `gnt`=0 in the same cycle, without waiting for a clock edge.
